// File: rtl/rgbw_scaler.sv
// rgbw_scaler: walks R, G, B, W through an external 8x8 multiplier and
// commits the rounded, intensity-scaled duty values as one atomic set.
module rgbw_scaler #(
    parameter int TIMEOUT = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  col_r,
    input  logic [7:0]  col_g,
    input  logic [7:0]  col_b,
    input  logic [7:0]  col_w,
    input  logic [7:0]  intensity,
    output logic        mult_ld,
    output logic [7:0]  mult_a,
    output logic [7:0]  mult_b,
    input  logic        mult_rdy,
    input  logic [15:0] mult_result,
    output logic [7:0]  duty_r,
    output logic [7:0]  duty_g,
    output logic [7:0]  duty_b,
    output logic [7:0]  duty_w,
    output logic        duty_valid,
    output logic        busy,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_RDY, WAIT_CLR, COMMIT} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t        r_state;
    logic          r_start_q;
    logic [1:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_snap [4];
    logic [7:0]    r_shadow [4];
    logic          w_edge;
    logic          w_timeout;
    logic [7:0]    w_scaled;
    assign w_edge    = start & ~r_start_q;
    assign w_timeout = r_cnt == CW'(TIMEOUT - 1);
    assign w_scaled  = 8'((mult_result + 16'h0080) >> 8);
    // Operands are registered on the transition into LOAD so mult_ld is
    // already high during LOAD and mult_a/mult_b never move while it is.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_start_q  <= 1'b0;
            r_idx      <= '0;
            r_cnt      <= '0;
            mult_ld    <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
            duty_r     <= '0;
            duty_g     <= '0;
            duty_b     <= '0;
            duty_w     <= '0;
            duty_valid <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_snap[k]   <= '0;
                r_shadow[k] <= '0;
            end
        end else begin
            r_start_q  <= start;
            duty_valid <= 1'b0;
            case (r_state)
                IDLE: if (w_edge) begin
                    r_snap[0] <= col_r;
                    r_snap[1] <= col_g;
                    r_snap[2] <= col_b;
                    r_snap[3] <= col_w;
                    mult_a    <= col_r;
                    mult_b    <= intensity;
                    mult_ld   <= 1'b1;
                    err       <= 1'b0;
                    busy      <= 1'b1;
                    r_idx     <= '0;
                    r_state   <= LOAD;
                end
                LOAD: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_RDY;
                end
                WAIT_RDY: if (mult_rdy) begin
                    r_shadow[r_idx] <= w_scaled;
                    mult_ld         <= 1'b0;
                    r_cnt           <= '0;
                    r_state         <= WAIT_CLR;
                end else if (w_timeout) begin
                    err     <= 1'b1;
                    mult_ld <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                WAIT_CLR: if (!mult_rdy) begin
                    if (r_idx == 2'd3) begin
                        r_state <= COMMIT;
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        mult_a  <= r_snap[r_idx + 2'd1];
                        mult_ld <= 1'b1;
                        r_state <= LOAD;
                    end
                end else if (w_timeout) begin
                    err     <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                COMMIT: begin
                    duty_r     <= r_shadow[0];
                    duty_g     <= r_shadow[1];
                    duty_b     <= r_shadow[2];
                    duty_w     <= r_shadow[3];
                    duty_valid <= 1'b1;
                    busy       <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rgbw_scaler.sv
// tb_rgbw_scaler: table and random checks of rgbw_scaler against a
// behavioural multiplier and an arithmetic reference of the scaling rule.
module tb_rgbw_scaler;
    localparam int TIMEOUT = 31;
    localparam int LAT_EXP = 26;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [7:0]  col_r, col_g, col_b, col_w, intensity;
    logic        mult_ld, mult_rdy, duty_valid, busy, err;
    logic [7:0]  mult_a, mult_b, duty_r, duty_g, duty_b, duty_w;
    logic [15:0] mult_result;
    int total = 0, bad = 0, vcount = 0;
    int m_lat = 3, m_hold = 0, m_cnt = 0, m_hc = 0;
    bit m_never = 1'b0;

    typedef struct {
        logic [7:0] r, g, b, w, i, er, eg, eb, ew;
    } vec_t;
    vec_t tbl[4];

    rgbw_scaler #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .col_r(col_r), .col_g(col_g), .col_b(col_b), .col_w(col_w),
        .intensity(intensity), .mult_ld(mult_ld), .mult_a(mult_a),
        .mult_b(mult_b), .mult_rdy(mult_rdy), .mult_result(mult_result),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b), .duty_w(duty_w),
        .duty_valid(duty_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Multiplier: product appears m_lat cycles into a load, stays ready
    // until ld drops plus m_hold extra cycles.
    always @(posedge clk) begin
        if (!reset) begin
            mult_rdy <= 1'b0; mult_result <= '0; m_cnt <= 0; m_hc <= 0;
        end else if (mult_rdy) begin
            if (!mult_ld) begin
                if (m_hc >= m_hold) mult_rdy <= 1'b0;
                else m_hc <= m_hc + 1;
            end
        end else if (mult_ld && !m_never) begin
            if (m_cnt >= m_lat - 1) begin
                mult_rdy <= 1'b1;
                mult_result <= {8'h0, mult_a} * {8'h0, mult_b};
                m_cnt <= 0; m_hc <= 0;
            end else m_cnt <= m_cnt + 1;
        end
    end

    always @(posedge clk) if (duty_valid) vcount <= vcount + 1;

    function automatic logic [7:0] ref_scale(input logic [7:0] c, input logic [7:0] i);
        return 8'((int'(c) * int'(i) + 128) / 256);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_set(input logic [7:0] r, g, b, w, i, input int bump, output int lat);
        logic [31:0] prev;
        bit held;
        prev = {duty_r, duty_g, duty_b, duty_w};
        held = 1'b1;
        col_r = r; col_g = g; col_b = b; col_w = w; intensity = i;
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = (lat == bump);
            if (lat == bump) begin
                col_r = 8'($urandom); col_g = 8'($urandom); col_b = 8'($urandom);
                col_w = 8'($urandom); intensity = 8'($urandom);
            end
            if (!duty_valid && {duty_r, duty_g, duty_b, duty_w} != prev) held = 1'b0;
        end while (!duty_valid && lat < 400);
        chk("duty_held", 32'(held), 1);
        chk("valid_seen", 32'(duty_valid), 1);
    endtask

    task automatic check_set(input logic [7:0] er, eg, eb, ew);
        chk("duty_r", 32'(duty_r), 32'(er));
        chk("duty_g", 32'(duty_g), 32'(eg));
        chk("duty_b", 32'(duty_b), 32'(eb));
        chk("duty_w", 32'(duty_w), 32'(ew));
        @(negedge clk);
        chk("valid_one_cycle", 32'(duty_valid), 0);
        chk("busy_after", 32'(busy), 0);
        chk("err_after", 32'(err), 0);
    endtask

    initial begin
        int lat, v0;
        logic [7:0] r, g, b, w, i;
        logic [31:0] prev;
        bit quiet;
        tbl[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE};
        tbl[1] = '{8'h80, 8'h00, 8'h40, 8'h01, 8'h80, 8'h40, 8'h00, 8'h20, 8'h01};
        tbl[2] = '{8'h10, 8'hFF, 8'h7F, 8'h01, 8'h10, 8'h01, 8'h10, 8'h08, 8'h00};
        tbl[3] = '{8'hAA, 8'h55, 8'hFF, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        reset = 1'b0; start = 1'b0;
        col_r = '0; col_g = '0; col_b = '0; col_w = '0; intensity = '0;
        repeat (3) @(negedge clk);
        chk("rst_duty", {duty_r, duty_g, duty_b, duty_w}, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ld", 32'(mult_ld), 0);
        chk("rst_ab", {mult_a, mult_b}, 0);
        chk("rst_valid", 32'(duty_valid), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            v0 = vcount;
            run_set(tbl[k].r, tbl[k].g, tbl[k].b, tbl[k].w, tbl[k].i, 0, lat);
            if (k == 0) chk("latency", lat, LAT_EXP);
            check_set(tbl[k].er, tbl[k].eg, tbl[k].eb, tbl[k].ew);
            chk("pulse_count", vcount - v0, 1);
        end

        // Inputs and start toggled mid-sequence must not disturb the snapshot.
        v0 = vcount;
        run_set(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 5, lat);
        check_set(ref_scale(8'h12, 8'h9A), ref_scale(8'h34, 8'h9A),
                  ref_scale(8'h56, 8'h9A), ref_scale(8'h78, 8'h9A));
        repeat (10) @(negedge clk);
        chk("busy_edge_pulses", vcount - v0, 1);

        // Start edge landing on the commit cycle is dropped.
        v0 = vcount;
        run_set(8'h20, 8'h40, 8'h60, 8'h80, 8'hC0, LAT_EXP - 1, lat);
        chk("commit_edge_lat", lat, LAT_EXP);
        check_set(ref_scale(8'h20, 8'hC0), ref_scale(8'h40, 8'hC0),
                  ref_scale(8'h60, 8'hC0), ref_scale(8'h80, 8'hC0));
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (busy) quiet = 1'b0;
        end
        chk("commit_edge_ignored", 32'(quiet), 1);
        chk("commit_edge_pulses", vcount - v0, 1);

        // Multiplier that never answers.
        m_never = 1'b1;
        prev = {duty_r, duty_g, duty_b, duty_w};
        v0 = vcount;
        col_r = 8'h01; start = 1'b1; lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = 1'b0;
        end while (!err && lat < 200);
        chk("to_err", 32'(err), 1);
        chk("to_window", 32'(lat >= TIMEOUT && lat <= TIMEOUT + 5), 1);
        chk("to_busy", 32'(busy), 0);
        chk("to_ld", 32'(mult_ld), 0);
        chk("to_duty_kept", {duty_r, duty_g, duty_b, duty_w}, prev);
        chk("to_no_valid", vcount - v0, 0);
        m_never = 1'b0;
        @(negedge clk);
        run_set(8'h80, 8'h00, 8'h40, 8'h01, 8'h80, 0, lat);
        check_set(8'h40, 8'h00, 8'h20, 8'h01);

        // Reset during the blue channel wait.
        start = 1'b1;
        col_r = 8'h11; col_g = 8'h22; col_b = 8'h33; col_w = 8'h44; intensity = 8'h55;
        repeat (15) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort_on_b", 32'(mult_a), 32'h33);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_duty", {duty_r, duty_g, duty_b, duty_w}, 0);
        chk("abort_ctl", {busy, err, mult_ld, duty_valid}, 0);
        chk("abort_ab", {mult_a, mult_b}, 0);
        reset = 1'b1;
        @(negedge clk);
        run_set(8'hFF, 8'h80, 8'h40, 8'h02, 8'hFF, 0, lat);
        chk("post_abort_lat", lat, LAT_EXP);
        check_set(ref_scale(8'hFF, 8'hFF), ref_scale(8'h80, 8'hFF),
                  ref_scale(8'h40, 8'hFF), ref_scale(8'h02, 8'hFF));

        // Ready held high long after each load drops.
        m_hold = 20;
        v0 = vcount;
        run_set(8'hC8, 8'h64, 8'h32, 8'h19, 8'hE0, 0, lat);
        check_set(ref_scale(8'hC8, 8'hE0), ref_scale(8'h64, 8'hE0),
                  ref_scale(8'h32, 8'hE0), ref_scale(8'h19, 8'hE0));
        chk("hold_pulses", vcount - v0, 1);
        m_hold = 0;

        for (int n = 0; n < 16; n++) begin
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            w = 8'($urandom); i = 8'($urandom);
            m_lat = 1 + int'($urandom_range(4));
            m_hold = int'($urandom_range(3));
            run_set(r, g, b, w, i, 0, lat);
            check_set(ref_scale(r, i), ref_scale(g, i), ref_scale(b, i), ref_scale(w, i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
